// File: rtl/cache_pkg.sv
// Shared constants for the cache miss-fill controller: block geometry and
// FSM state encoding.
package cache_pkg;
  localparam int BLOCK_WORDS = 8;
  localparam int WORD_OFS_W  = $clog2(BLOCK_WORDS);
  localparam int CNT_W       = WORD_OFS_W + 1;

  // Byte-offset bits inside one block (16-bit words, so twice the word count)
  localparam logic [15:0] BLK_OFS_MASK = 16'(2 * BLOCK_WORDS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;
endpackage

// File: rtl/cache_fill_fsm_if.sv
// Cache-side and memory-side signals of one fill controller, bundled so the
// controller (master) and its surroundings (slave) share one declaration.
interface cache_fill_fsm_if import cache_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int OFS_W  = WORD_OFS_W
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              fsm_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] memory_address;
  logic              memory_data_valid;
  logic              write_data_array;
  logic [OFS_W-1:0]  fill_word;
  logic              write_tag_array;

  modport master (
    input  miss_detected, miss_address, memory_data_valid,
    output fsm_busy, mem_req, memory_address, write_data_array, fill_word,
           write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid,
    input  fsm_busy, mem_req, memory_address, write_data_array, fill_word,
           write_tag_array
  );
endinterface

// File: rtl/add_sub_16.sv
// Library 16-bit adder/subtractor cell.
module add_sub_16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic [15:0] y_o
);
  assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
endmodule

// File: rtl/dff.sv
// Library flop cell: W-bit register with asynchronous active-high reset to 0.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_o <= '0;
    else     q_o <= d_i;
  end
endmodule

// File: rtl/fill_counter.sv
// Word counter for one side of a block fill: synchronous clear has priority
// over increment; storage is a library dff cell.
module fill_counter import cache_pkg::*; #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  dff #(.W(W)) u_cnt_dff (
    .clk (clk),
    .rst (rst),
    .d_i (cnt_d),
    .q_o (cnt_q)
  );

  assign cnt_o = cnt_q;
endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: stalls the pipeline, streams one block from main
// memory and writes each returned word, then the tag, into the cache arrays.
module cache_fill_fsm import cache_pkg::*; #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_fill_fsm_if.master      bus
);
  localparam int OFS_W = $clog2(BLOCK_WORDS);
  localparam int CW    = OFS_W + 1;
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     issue_cnt, recv_cnt;
  logic [15:0]       addr_sum;
  logic              in_fill, start, issue_en, recv_en, last_word;

  assign in_fill   = (state_q == ST_FILL);
  assign start     = (state_q == ST_IDLE) && bus.miss_detected;
  assign issue_en  = in_fill && (issue_cnt < CW'(BLOCK_WORDS));
  // Returns beyond the last word of the block are dropped, never written
  assign recv_en   = in_fill && bus.memory_data_valid && (recv_cnt < CW'(BLOCK_WORDS));
  assign last_word = recv_en && (recv_cnt == CW'(BLOCK_WORDS - 1));

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    if (start) begin
      state_d = ST_FILL;
      base_d  = bus.miss_address & ~OFS_MASK;
    end else if (last_word) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  fill_counter #(.W(CW)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .en_i  (issue_en),
    .cnt_o (issue_cnt)
  );

  fill_counter #(.W(CW)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .en_i  (recv_en),
    .cnt_o (recv_cnt)
  );

  // Word index doubled into a byte offset; base is block-aligned so no carry-out
  add_sub_16 u_addr_add (
    .a_i   (base_q),
    .b_i   ({{(16 - CW - 1){1'b0}}, issue_cnt, 1'b0}),
    .sub_i (1'b0),
    .y_o   (addr_sum)
  );

  assign bus.fsm_busy         = in_fill | start;
  assign bus.mem_req          = issue_en;
  assign bus.memory_address   = issue_en ? addr_sum : '0;
  assign bus.write_data_array = recv_en;
  assign bus.fill_word        = recv_en ? recv_cnt[OFS_W-1:0] : '0;
  assign bus.write_tag_array  = last_word;
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomised bench for cache_fill_fsm against a transaction-level fill model
// with an in-order memory of configurable, possibly irregular, latency.
module tb_cache_fill_fsm;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_W(16), .OFS_W(3)) bus ();

  cache_fill_fsm #(.BLOCK_WORDS(8), .ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: a fill is "block base, words asked for, words received"
  bit          m_fill = 1'b0;
  logic [15:0] m_base = '0;
  int          m_iss = 0, m_rcv = 0;
  bit          e_req, e_wr, e_tag;

  // Memory environment
  int ret_q[$];
  int lat_first = 4, lat_rest = 4, n_req_fill = 0;
  bit gappy = 1'b0, force_v = 1'b0;

  // Per-fill observations
  int start_cyc, first_req_cyc, first_wr_cyc, tag_cyc, n_wr, n_tag;
  logic [15:0] first_addr, last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic [15:0] e_addr;
    e_req  = m_fill && (m_iss < 8);
    e_wr   = m_fill && bus.memory_data_valid && (m_rcv < 8);
    e_tag  = e_wr && (m_rcv == 7);
    e_addr = m_base + 16'(2 * m_iss);
    chk("fsm_busy", bus.fsm_busy, m_fill || bus.miss_detected);
    chk("mem_req", bus.mem_req, e_req);
    chk("write_data_array", bus.write_data_array, e_wr);
    chk("write_tag_array", bus.write_tag_array, e_tag);
    if (e_req) chk("memory_address", bus.memory_address, e_addr);
    if (e_wr)  chk("fill_word", bus.fill_word, m_rcv);
    if (bus.mem_req && !rst) begin
      ret_q.push_back(cyc + ((n_req_fill < 4) ? lat_first : lat_rest));
      n_req_fill++;
      if (first_req_cyc < 0) first_addr = bus.memory_address;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      last_addr = bus.memory_address;
    end
    if (bus.write_data_array) begin
      chk("fill_word_seq", bus.fill_word, n_wr % 8);
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      n_wr++;
    end
    if (bus.write_tag_array) begin
      n_tag++;
      tag_cyc = cyc;
    end
  endtask

  task automatic update();
    if (rst) begin
      m_fill = 1'b0;
      ret_q.delete();
    end else if (!m_fill) begin
      if (bus.miss_detected) begin
        m_fill = 1'b1;
        m_base = bus.miss_address & 16'hFFF0;
        m_iss = 0;
        m_rcv = 0;
        start_cyc = cyc;
        first_req_cyc = -1;
        first_wr_cyc = -1;
        tag_cyc = -1;
        n_wr = 0;
        n_tag = 0;
        n_req_fill = 0;
      end
    end else begin
      if (e_req) m_iss++;
      if (e_wr)  m_rcv++;
      if (e_tag) m_fill = 1'b0;
    end
  endtask

  task automatic drive_mem();
    if (ret_q.size() > 0 && ret_q[0] <= cyc && (!gappy || $urandom_range(0, 2) != 0)) begin
      bus.memory_data_valid = 1'b1;
      void'(ret_q.pop_front());
    end else begin
      bus.memory_data_valid = force_v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    update();
    #1;
    cyc++;
    drive_mem();
  endtask

  task automatic cycle_end();
    @(negedge clk);
    compare();
    tick();
  endtask

  task automatic run_fill(input logic [15:0] addr, input int lf, input int lr, input bit gap);
    int guard;
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    lat_first = lf;
    lat_rest  = lr;
    gappy     = gap;
    guard     = 0;
    cycle_end();
    while (m_fill && guard < 300) begin
      cycle_end();
      guard++;
    end
    chk("fill_timeout", guard < 300, 1);
    chk("fill_data_writes", n_wr, 8);
    chk("fill_tag_writes", n_tag, 1);
    bus.miss_detected = 1'b0;
    gappy = 1'b0;
  endtask

  initial begin
    int prev_tag, wr_before;
    logic [15:0] a;
    rst = 1'b1;
    bus.miss_detected = 1'b0;
    bus.miss_address = '0;
    bus.memory_data_valid = 1'b0;
    #2;
    chk("rst_busy", bus.fsm_busy, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_addr", bus.memory_address, 0);
    chk("rst_wr", bus.write_data_array, 0);
    chk("rst_fw", bus.fill_word, 0);
    chk("rst_tag", bus.write_tag_array, 0);
    tick();
    cycle_end();
    rst = 1'b0;
    cycle_end();

    // Basic fill with 4-cycle memory
    run_fill(16'h1236, 4, 4, 1'b0);
    chk("basic_base", m_base, 16'h1230);
    chk("basic_first_req_ofs", first_req_cyc - start_cyc, 1);
    chk("basic_first_addr", first_addr, 16'h1230);
    chk("basic_last_addr", last_addr, 16'h123E);
    chk("basic_first_wr_ofs", first_wr_cyc - start_cyc, 5);
    chk("basic_tag_ofs", tag_cyc - start_cyc, 12);
    cycle_end();

    // Top of memory
    run_fill(16'hFFFF, 3, 3, 1'b0);
    chk("top_first_addr", first_addr, 16'hFFF0);
    chk("top_last_addr", last_addr, 16'hFFFE);
    cycle_end();

    // Irregular returns, then spurious valids while idle
    run_fill(16'h0A5C, 1, 6, 1'b1);
    chk("irr_first_addr", first_addr, 16'h0A50);
    wr_before = n_wr;
    force_v = 1'b1;
    bus.memory_data_valid = 1'b1;
    repeat (3) cycle_end();
    force_v = 1'b0;
    chk("spurious_no_write", n_wr, wr_before);
    cycle_end();

    // Reset in cycle 7 of a fill
    bus.miss_detected = 1'b1;
    bus.miss_address = 16'h2468;
    lat_first = 4;
    lat_rest = 4;
    repeat (7) cycle_end();
    bus.miss_detected = 1'b0;
    #2;
    rst = 1'b1;
    m_fill = 1'b0;
    ret_q.delete();
    #1;
    chk("arst_busy", bus.fsm_busy, 0);
    chk("arst_mem_req", bus.mem_req, 0);
    chk("arst_addr", bus.memory_address, 0);
    chk("arst_wr", bus.write_data_array, 0);
    chk("arst_tag", bus.write_tag_array, 0);
    chk("arst_no_tag", n_tag, 0);
    cycle_end();
    rst = 1'b0;
    cycle_end();
    run_fill(16'h0040, 4, 4, 1'b0);
    chk("post_rst_first_addr", first_addr, 16'h0040);
    chk("post_rst_last_addr", last_addr, 16'h004E);

    // Back-to-back misses
    run_fill(16'h3000, 4, 4, 1'b0);
    prev_tag = tag_cyc;
    run_fill(16'h5557, 2, 5, 1'b0);
    chk("b2b_start", start_cyc, prev_tag + 1);
    chk("b2b_first_req", first_req_cyc, prev_tag + 2);
    chk("b2b_first_addr", first_addr, 16'h5550);
    cycle_end();

    // Random fills
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom);
      run_fill(a, $urandom_range(1, 8), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
      chk("rnd_first_addr", first_addr, a & 16'hFFF0);
      chk("rnd_last_addr", last_addr, (a & 16'hFFF0) + 16'd14);
      repeat ($urandom_range(0, 2)) cycle_end();
    end
    cycle_end();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the pipelined CPU's cache arrays and the multi-cycle main memory. On a cache miss it stalls the pipeline, streams an 8-word (16-byte) block from memory, and emits one data-array write per returned word plus a single tag-array write when the block is complete. One instance serves the instruction side (feeding the IF stage) and one the data side (feeding the MEM stage).

## Interface
Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block (power of two)
- ADDR_W, 16, byte-address width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- miss_detected  in  1  cache lookup missed this cycle (level, held by cache until fill done)
- miss_address  in  ADDR_W  byte address of the missing access
- fsm_busy  out  1  stall to pipeline; high while a fill is pending or active
- mem_req  out  1  read request to memory this cycle
- memory_address  out  ADDR_W  byte address of the requested word
- memory_data_valid  in  1  memory returns one word this cycle (in request order)
- write_data_array  out  1  write returned word into cache data array
- fill_word  out  log2(BLOCK_WORDS)  word offset within block for current data write
- write_tag_array  out  1  write tag/valid for the block at miss_address

## Operation
- States: IDLE, FILL. State, block base, issue counter, receive counter held in flops.
- IDLE: if miss_detected, latch base = miss_address with low log2(BLOCK_WORDS)+1 bits cleared, clear both counters, go to FILL. Otherwise stay.
- fsm_busy = (state==FILL) | (state==IDLE & miss_detected); combinational so the stall takes effect in the miss cycle.
- FILL, issue side: while issue_cnt < BLOCK_WORDS, mem_req=1, memory_address = base + 2*issue_cnt, issue_cnt++ each cycle. After 8 issues mem_req=0.
- FILL, receive side: on memory_data_valid, write_data_array=1, fill_word = recv_cnt, recv_cnt++. Issue and receive overlap freely.
- Completion: the cycle the 8th valid arrives, write_data_array=1, fill_word=7 and write_tag_array=1 together; next state IDLE.
- memory_data_valid outside FILL, or after the 8th word, ignored (no writes).
- miss_detected during FILL ignored; a new miss is sampled only in IDLE.
- Counters are log2(BLOCK_WORDS)+1 bits; no wrap inside a fill. Base is block-aligned, so base+14 never overflows (0xFFF0 → last word 0xFFFE).

## Timing
- Reset values: state=IDLE, counters=0, base=0; fsm_busy=0 (unless miss_detected), mem_req=0, memory_address=0, write_data_array=0, fill_word=0, write_tag_array=0.
- Miss sampled in IDLE at cycle 0; requests in cycles 1–8, addresses base, base+2, …, base+14.
- With 4-cycle memory: valids cycles 5–12; tag write cycle 12; IDLE and fsm_busy low (miss_detected dropped by cache after tag write) cycle 13. Miss penalty = 8 + memory latency + 1 cycles.
- Reset asserted mid-fill: immediate return to IDLE, all outputs 0, no tag write; partially written block stays invalid because its tag was never written.
- Memory back-pressure is not modelled; memory accepts one request per cycle.

## Structure
- Shared package (cache_pkg): state encoding (IDLE=0, FILL=1), BLOCK_WORDS, WORD_OFS_W = log2(BLOCK_WORDS), CNT_W = WORD_OFS_W+1, block-offset mask.
- One sub-module: fill_counter (CNT_W-bit, clear + increment enable, built from existing dff cells, async reset), instantiated twice (issue, receive).
- Address adder reuses add_sub_16 with B = {issue_cnt, 1'b0}.

## Test plan
- Reset: assert rst mid-cycle with miss_detected=0 → all outputs 0 asynchronously, state IDLE.
- Basic fill, latency 4: miss at 0x1236 → base 0x1230; mem_req cycles 1–8 with 0x1230…0x123E; write_data_array cycles 5–12 with fill_word 0…7; write_tag_array only cycle 12; fsm_busy high cycles 0–12.
- Top-of-memory: miss at 0xFFFF → addresses 0xFFF0…0xFFFE, no wrap, 8 data writes, 1 tag write.
- Irregular valids (gaps, latency 1 then 6) → exactly 8 data writes with fill_word strictly 0…7, tag write with the 8th; spurious valid in IDLE → no write.
- Reset at cycle 7 of a fill → no tag write, IDLE next; subsequent miss at 0x0040 → clean fill of 0x0040…0x004E.
- Back-to-back misses: second miss_detected held from cycle 13 → new fill starts cycle 13, first request cycle 14.
